// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Pipeline register stage with valid/ready handshaking. With SKID=1 it holds
// up to two entries (main + skid) so that in_ready can be a registered signal
// with no combinational path from out_ready. With SKID=0 it degenerates to a
// single stall register whose in_ready is combinational.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous kill of every held entry (and of a same-cycle input)
//   in_valid   upstream entry present
//   in_ready   stage accepts an entry this cycle
//   in_data    upstream payload           [DATA_W]
//   in_ctrl    upstream control bits      [CTRL_W]
//   out_valid  downstream entry present
//   out_ready  downstream consumes the head entry this cycle
//   out_data   head payload (holds its last value while empty)
//   out_ctrl   head control bits, forced to zero while empty
//   occupancy  number of held entries, 0..2
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_data_reg, skid_data_reg;
  logic [CTRL_W-1:0] main_ctrl_reg, skid_ctrl_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = main_data_reg;
  // A bubble must never present a live write enable downstream.
  assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
  assign occupancy = state_reg;
  assign stall_cnt = stall_cnt_reg;

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_reg;

      // Registered ready: look ahead at the next state so the stage never
      // advertises room it will not have.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != TWO);
        end
      end

      assign in_ready = in_ready_reg;
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next-state and register-load decode.
  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        // Without a skid register an accept while full implies a pop, so the
        // SKID==0 term only documents that TWO is never entered there.
        if (accept && (pop || (SKID == 0))) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // Squash wins over everything; a pop in the same cycle still completes
    // downstream because the head was already presented this cycle.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Payload registers; they are not cleared by flush so out_data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_data_reg <= in_data;
        main_ctrl_reg <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_reg <= skid_data_reg;
        main_ctrl_reg <= skid_ctrl_reg;
      end
      if (load_skid) begin
        skid_data_reg <= in_data;
        skid_ctrl_reg <= in_ctrl;
      end
    end
  end

  // Stall counter: independent of flush, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (pc, alu result, operands, inst).
REQ-002 Parameter CTRL_W, default 9, width of the control payload (write-back select, memory controls, write enable).
REQ-003 Parameter SKID, default 1; 1 selects a two-entry skid stage, 0 selects a single-entry stall register.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  synchronous kill of all held entries (branch or exception squash).
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage accepts an entry this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control bits.
REQ-012 out_valid  output  1  downstream entry present.
REQ-013 out_ready  input  1  downstream consumes the entry this cycle.
REQ-014 out_data  output  DATA_W  head payload.
REQ-015 out_ctrl  output  CTRL_W  head control bits, gated.
REQ-016 occupancy  output  2  number of held entries (0..2).
REQ-017 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 The transfer rules SHALL be: accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 With SKID=1, the block SHALL implement the states EMPTY, ONE and TWO, and occupancy SHALL equal 0, 1 and 2 respectively.
REQ-020 In SKID=1 mode, in_ready SHALL be a registered output equal to (state != TWO), with no combinational path from out_ready.
REQ-021 EMPTY transitions: accept -> ONE, with the main register loaded from the input; otherwise EMPTY.
REQ-022 ONE transitions: accept & pop -> ONE, main loaded from input; accept & !pop -> TWO, skid register loaded from input; pop & !accept -> EMPTY; neither -> ONE.
REQ-023 TWO transitions: pop -> ONE, main loaded from skid; otherwise TWO, no register changes.
REQ-024 out_valid SHALL equal (state != EMPTY), and out_data/out_ctrl SHALL always source the main register.
REQ-025 Entry order SHALL be preserved: no entry is lost, duplicated or reordered.
REQ-026 With SKID=0, the block SHALL use a single register: in_ready = !out_valid | out_ready (combinational), occupancy SHALL never exceed 1, and TWO SHALL be unreachable.
REQ-027 Latency SHALL be 1 cycle from accept to out_valid when the stage is empty, in both modes.
REQ-028 out_ctrl SHALL read all-zero whenever out_valid=0, so that no write enable leaks from a bubble; out_data SHALL hold its last value.
REQ-029 flush=1 SHALL take priority over all other events: next state EMPTY, occupancy 0, and a same-cycle input discarded even if in_valid=1.
REQ-030 A same-cycle pop during flush SHALL still complete downstream.
REQ-031 After flush, in_ready SHALL be 1 on the next cycle.
REQ-032 stall_cnt SHALL increment by 1 per stall cycle, saturate at 2^CNT_W-1, and be unaffected by flush.

Reset
REQ-033 On rst=1, the block SHALL immediately set: state EMPTY, out_valid 0, out_data 0, out_ctrl 0, skid register 0, occupancy 0, stall_cnt 0.
REQ-034 On rst=1, in_ready SHALL be 1 in SKID=1 mode, and SHALL evaluate to 1 in SKID=0 mode.
REQ-035 Assertion of rst mid-operation SHALL drop all held entries, with no output glitch toward a valid entry.

Verification
REQ-036 SKID=1, out_ready=1, in_valid=1 streaming data 1,2,3,... -> out_data 1,2,3 one cycle later each, occupancy stays 1, stall_cnt stays 0.
REQ-037 SKID=1, hold out_ready=0, offer A then B -> occupancy 1 then 2, in_ready 0, C is not accepted; raise out_ready -> A, B, C appear in order, stall_cnt = number of held cycles.
REQ-038 SKID=1, state TWO, flush=1 with in_valid=1, in_data=0x55 -> next cycle out_valid 0, out_ctrl 0, occupancy 0, in_ready 1, and 0x55 never appears.
REQ-039 SKID=0, out_ready toggling 1,0,1,0 with continuous input -> in_ready mirrors !out_valid | out_ready combinationally, occupancy never exceeds 1, order is preserved.
REQ-040 CNT_W=2, out_ready=0 for 6 cycles with out_valid=1 -> stall_cnt reads 1,2,3,3,3,3.
REQ-041 Async rst pulsed mid-cycle in state TWO -> outputs zero before the next clock edge, and the stream resumes from EMPTY.
